// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the sequence-detector slice.
package seq_det_pkg;

    typedef enum logic {
        IDLE,
        COUNT
    } ctrl_state_t;

    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned WIN_LEN_DEF = 16;

    // Bits needed to hold a window timer counting 0..win_len-1.
    function automatic int unsigned timer_w(input int unsigned win_len);
        return $clog2(win_len);
    endfunction

    localparam int unsigned TIMER_W = timer_w(WIN_LEN_DEF);

endpackage

// File: rtl/det_window_counter_if.sv
// Reader-side bus of det_window_counter: detector/reader inputs and published window result.
interface det_window_counter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             det;
    logic             en;
    logic             rd_ack;
    logic [CNT_W-1:0] win_count;
    logic             win_sat;
    logic             win_valid;
    logic             overrun;

    modport master (
        output det, en, rd_ack,
        input  win_count, win_sat, win_valid, overrun
    );

    modport slave (
        input  det, en, rd_ack,
        output win_count, win_sat, win_valid, overrun
    );
endinterface

// File: rtl/det_window_timer.sv
// Modulo-WIN_LEN cycle timer; o_last marks the stepping edge that closes a window.
module det_window_timer
    import seq_det_pkg::*;
#(
    parameter int unsigned WIN_LEN = WIN_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_step,
    output logic o_last
);
    localparam int unsigned TW = timer_w(WIN_LEN);

    logic [TW-1:0] r_timer;
    logic          w_at_end;

    assign w_at_end = (r_timer == TW'(WIN_LEN - 1));
    assign o_last   = i_step & w_at_end;

    // Advance once per counted cycle, wrapping at the window end.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_timer <= '0;
        end else if (i_step) begin
            r_timer <= w_at_end ? '0 : r_timer + TW'(1);
        end
    end
endmodule

// File: rtl/det_window_counter.sv
// Counts det pulses per WIN_LEN-cycle window and publishes each result
// through a hold-until-acknowledged register with a sticky overrun flag.
module det_window_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned WIN_LEN = WIN_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    det_window_counter_if.slave  bus
);
    ctrl_state_t      r_state;
    logic [CNT_W-1:0] r_acc;
    logic             r_sat;
    logic [CNT_W-1:0] r_win_count;
    logic             r_win_sat;
    logic             r_win_valid;
    logic             r_overrun;

    logic             w_step;
    logic             w_last;
    logic             w_acc_max;
    logic [CNT_W-1:0] w_sum;
    logic             w_sat_next;

    assign w_step     = (r_state == COUNT) && bus.en;
    assign w_acc_max  = &r_acc;
    assign w_sum      = w_acc_max ? r_acc : r_acc + CNT_W'(bus.det);
    assign w_sat_next = r_sat | (w_acc_max & bus.det);

    det_window_timer #(
        .WIN_LEN (WIN_LEN)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (~w_step),
        .i_step  (w_step),
        .o_last  (w_last)
    );

    // Control FSM, saturating accumulator and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_win_count <= '0;
            r_win_sat   <= 1'b0;
            r_win_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_acc <= '0;
                    r_sat <= 1'b0;
                    if (bus.en) r_state <= COUNT;
                end
                COUNT: begin
                    if (!bus.en) begin
                        r_state <= IDLE;
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                    end else if (w_last) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end else begin
                        r_acc <= w_sum;
                        r_sat <= w_sat_next;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A window end frees the slot if the reader acks on the same edge.
            if (w_last) begin
                if (!r_win_valid || bus.rd_ack) begin
                    r_win_count <= w_sum;
                    r_win_sat   <= w_sat_next;
                    r_win_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (bus.rd_ack && r_win_valid) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign bus.win_count = r_win_count;
    assign bus.win_sat   = r_win_sat;
    assign bus.win_valid = r_win_valid;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_det_window_counter.sv
// Bench for det_window_counter: directed windows then random traffic,
// two instances (CNT_W=8 and CNT_W=2) checked against an integer window model.
module tb_det_window_counter;
    localparam int unsigned WIN = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    det_window_counter_if #(.CNT_W(8)) bus8 ();
    det_window_counter_if #(.CNT_W(2)) bus2 ();

    det_window_counter #(.CNT_W(8), .WIN_LEN(WIN)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    det_window_counter #(.CNT_W(2), .WIN_LEN(WIN)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    // Model: unbounded count per window, saturation applied when compared.
    int m_counting, m_cyc, m_cnt, m_raw, m_valid, m_over;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_cnt(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    task automatic step(input logic r, input logic e, input logic d, input logic a);
        int win_end;
        int res;
        reset = r;
        bus8.en = e; bus8.det = d; bus8.rd_ack = a;
        bus2.en = e; bus2.det = d; bus2.rd_ack = a;
        @(posedge clk);
        win_end = 0;
        res = 0;
        if (r) begin
            m_counting = 0; m_cyc = 0; m_cnt = 0;
            m_raw = 0; m_valid = 0; m_over = 0;
        end else begin
            if (m_counting == 0) begin
                if (e) m_counting = 1;
            end else if (!e) begin
                m_counting = 0; m_cyc = 0; m_cnt = 0;
            end else begin
                m_cnt += int'(d);
                if (m_cyc == WIN - 1) begin
                    win_end = 1; res = m_cnt; m_cnt = 0; m_cyc = 0;
                end else begin
                    m_cyc++;
                end
            end
            if (win_end != 0) begin
                if (m_valid == 0 || a) begin
                    m_raw = res; m_valid = 1;
                end else begin
                    m_over = 1;
                end
            end else if (a && m_valid != 0) begin
                m_valid = 0;
            end
        end
        #1;
        chk("cnt8",   int'(bus8.win_count), sat_cnt(m_raw, 255));
        chk("sat8",   int'(bus8.win_sat),   int'(m_raw > 255));
        chk("valid8", int'(bus8.win_valid), m_valid);
        chk("ovr8",   int'(bus8.overrun),   m_over);
        chk("cnt2",   int'(bus2.win_count), sat_cnt(m_raw, 3));
        chk("sat2",   int'(bus2.win_sat),   int'(m_raw > 3));
        chk("valid2", int'(bus2.win_valid), m_valid);
        chk("ovr2",   int'(bus2.overrun),   m_over);
    endtask

    // One full window while counting; ack_cyc<0 means no ack.
    task automatic run_window(input logic [15:0] mask, input int ack_cyc);
        for (int c = 0; c < int'(WIN); c++) begin
            step(1'b0, 1'b1, mask[c], (c == ack_cyc));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_counting = 0; m_cyc = 0; m_cnt = 0; m_raw = 0; m_valid = 0; m_over = 0;
        reset = 1'b1;
        bus8.en = 0; bus8.det = 0; bus8.rd_ack = 0;
        bus2.en = 0; bus2.det = 0; bus2.rd_ack = 0;
        #1;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_valid", int'(bus8.win_valid), 0);
        chk("rst_count", int'(bus8.win_count), 0);

        // Pulses at window cycles 2, 5, 9.
        step(0, 1, 0, 0);
        run_window(16'h0224, -1);
        chk("t1_valid", int'(bus8.win_valid), 1);
        chk("t1_count", int'(bus8.win_count), 3);
        chk("t1_sat",   int'(bus8.win_sat),   0);

        // Only the last cycle pulses.
        run_window(16'h8000, 0);
        chk("t2_count", int'(bus8.win_count), 1);

        // det held for the whole window.
        run_window(16'hFFFF, 0);
        chk("t3_cnt2", int'(bus2.win_count), 3);
        chk("t3_sat2", int'(bus2.win_sat),   1);
        chk("t3_cnt8", int'(bus8.win_count), 16);

        // Ack on the window-end edge while full.
        run_window(16'h0111, 15);
        chk("t5_valid", int'(bus8.win_valid), 1);
        chk("t5_count", int'(bus8.win_count), 3);
        chk("t5_ovr",   int'(bus8.overrun),   0);

        // Two window ends without ack.
        run_window(16'h0003, -1);
        chk("t4_count", int'(bus8.win_count), 3);
        chk("t4_ovr",   int'(bus8.overrun),   1);
        run_window(16'h0007, -1);
        chk("t4_ovr2",  int'(bus8.overrun),   1);
        step(0, 1, 0, 1);
        chk("t4_ackv",  int'(bus8.win_valid), 0);
        chk("t4_ackov", int'(bus8.overrun),   1);

        // en dropped at window cycle 7 after two pulses.
        for (int c = 1; c < 7; c++) step(0, 1, (c == 1 || c == 3), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_nopub", int'(bus8.win_valid), 0);
        step(0, 1, 0, 0);
        run_window(16'h0400, -1);
        chk("t6_count", int'(bus8.win_count), 1);
        chk("t6_valid", int'(bus8.win_valid), 1);

        // Reset with a result pending.
        step(1, 0, 0, 0);
        chk("t7_valid", int'(bus8.win_valid), 0);
        chk("t7_count", int'(bus8.win_count), 0);
        chk("t7_ovr",   int'(bus8.overrun),   0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 97),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/det_window_counter.md
# det_window_counter

Downstream consumer of the serial sequence detector's `det` output. It counts detection pulses over fixed windows of `WIN_LEN` clock cycles. At the end of each window it publishes the count, with a saturation flag, through a hold-until-acknowledged output register. Its purpose is to turn single-cycle Mealy detection pulses into per-window statistics for a slower reader.

## Interface
- `CNT_W`, 8: width of the window count; the accumulator saturates at 2^CNT_W−1.
- `WIN_LEN`, 16: window length in counted cycles; legal range is 2..65535.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `det`  in  1  detection pulse from the upstream detector, sampled every rising edge.
- `en`  in  1  counting enable; low aborts the current window.
- `rd_ack`  in  1  reader acknowledge; meaningful only while `win_valid`=1.
- `win_count`  out  CNT_W  count of the last published window.
- `win_sat`  out  1  the published window saturated.
- `win_valid`  out  1  a published result is waiting for acknowledge.
- `overrun`  out  1  sticky: a window result was dropped.

## Operation
- Two-state control FSM.
  - IDLE: timer=0, acc=0; no counting.
  - COUNT: counting in progress.
- Transitions:
  - IDLE→COUNT on an edge with `en`=1. That edge does not count `det`.
  - COUNT→IDLE on an edge with `en`=0. The partial window is discarded; timer and acc clear; nothing is published.
- Counting, on every edge in COUNT with `en`=1:
  - acc ← sat(acc + det); timer ← timer+1.
  - Saturation: if acc is already 2^CNT_W−1 and det=1, acc holds and the internal sat bit is set.
- Window end: an edge in COUNT with `en`=1 and timer=WIN_LEN−1.
  - The result is sat(acc+det) plus the sat bit, including that edge's `det`.
  - timer, acc and the sat bit clear; the FSM stays in COUNT.
- Output register (EMPTY/FULL, where FULL ≡ `win_valid`):
  - Window end while EMPTY: load `win_count`/`win_sat`; `win_valid` ← 1.
  - `rd_ack` while FULL with no window end: `win_valid` ← 0. `win_count`/`win_sat` hold their last values.
  - Window end and `rd_ack` on the same edge while FULL: the new result loads and `win_valid` stays 1. No overrun.
  - Window end while FULL without `rd_ack`: the new result is dropped, the old data holds, and `overrun` ← 1.
  - `rd_ack` while EMPTY is ignored.
- `overrun` clears only on `reset`.

## Timing
- Reset values: `win_count`=0, `win_sat`=0, `win_valid`=0, `overrun`=0, FSM=IDLE, timer=0, acc=0.
- `reset` has priority over every other input on the same edge.
- `reset` mid-window discards all state, including any published-but-unacknowledged result.
- Latency: outputs update on the window-end edge and are visible in the following cycle. The first result appears WIN_LEN+1 edges after the first edge with `en`=1.
- All outputs are registered; there are no combinational paths from input to output.
- `det` is expected to be a clean 1-cycle pulse. A multi-cycle `det` counts once per cycle it is high.

## Structure
- Shared package `seq_det_pkg`:
  - control state enum {IDLE, COUNT};
  - default `CNT_W`/`WIN_LEN` localparams;
  - a `TIMER_W` helper computed as $clog2(WIN_LEN).
- One sub-module, `det_window_timer`: holds the modulo-WIN_LEN timer, takes clear/step inputs, and emits a `last` strobe.
- The accumulator, output register and FSM live in the top module.

## Test plan
- Reset for 2 cycles, then `en`=1 with `det` pulses at window cycles 2, 5 and 9 → after the window end, `win_valid`=1, `win_count`=3, `win_sat`=0.
- `det` high on the final window cycle only → `win_count`=1, confirming the last edge is included.
- With CNT_W=2 and `det` held high for a full 16-cycle window → `win_count`=3, `win_sat`=1.
- No `rd_ack` across two window ends → the first count holds, `overrun`=1 and stays 1. Then pulse `rd_ack` → `win_valid`=0 while `overrun` stays 1.
- `rd_ack` on the exact window-end edge → `win_valid` stays 1, the new count loads, `overrun`=0.
- `en` dropped at window cycle 7 with 2 pulses counted → no publish. Re-enable gives a fresh count from 0. Separately, assert `reset` with `win_valid`=1 → all outputs are 0 on the next cycle.
